dram_req_port: RTL and testbench

- Adapts the CPU/MMU DRAM side into single word-wide bus transactions with byte enables: load-enable/store strobes, RISC-V size/sign control, busy handshake.
- Performs byte-lane steering on stores and sign/zero extension on loads.
- Sits directly downstream of the CPU+MMU wrapper and upstream of the DRAM controller/arbiter.

---
 rtl/dram_req_port_pkg.sv | 52 +++++
 rtl/dram_req_port_if.sv | 44 ++++
 rtl/dram_req_port_lane_steer.sv | 38 +++
 rtl/dram_req_port.sv | 171 +++++++++++++++++
 tb/tb_dram_req_port.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/dram_req_port_pkg.sv
// ----------------------------------------------------------------------------
// dram_req_port_pkg
// Shared definitions for the DRAM request port:
//   - access size encodings SZ_B / SZ_H / SZ_W
//   - FSM state type
//   - size_bytes(): byte count of an access size
//   - lane_mask():  byte-lane mask over two consecutive words (low nibble is
//                   the first word, high nibble the spill into the next word)
//   - load_extend(): mask a right-justified load to size and sign/zero extend
// ----------------------------------------------------------------------------
package dram_req_port_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ1 = 2'd1,
        ST_REQ2 = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << off;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                                input logic [1:0]  size,
                                                input logic        uns);
        case (size)
            SZ_B:    return {{24{~uns & raw[7]}}, raw[7:0]};
            SZ_H:    return {{16{~uns & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

endpackage

// File: rtl/dram_req_port_if.sv
// ----------------------------------------------------------------------------
// Interfaces of the DRAM request port.
//   dram_cpu_if : CPU/MMU side. master = CPU, slave = request port.
//                 addr/wdata/ctrl/we_t/le toward the port, odata/busy back.
//   dram_mem_if : memory bus side. master = request port, slave = DRAM
//                 controller. req/we/addr/be/wdata out, rdata/ack back.
// ----------------------------------------------------------------------------
interface dram_cpu_if #(parameter int ADDR_W = 32);
    logic [ADDR_W-1:0] w_dram_addr;
    logic [31:0]       w_dram_wdata;
    logic [31:0]       w_dram_odata;
    logic              w_dram_we_t;
    logic              w_dram_le;
    logic [2:0]        w_dram_ctrl;
    logic              w_dram_busy;

    modport master (
        output w_dram_addr, w_dram_wdata, w_dram_we_t, w_dram_le, w_dram_ctrl,
        input  w_dram_odata, w_dram_busy
    );
    modport slave (
        input  w_dram_addr, w_dram_wdata, w_dram_we_t, w_dram_le, w_dram_ctrl,
        output w_dram_odata, w_dram_busy
    );
endinterface

interface dram_mem_if #(parameter int ADDR_W = 32);
    logic              w_mem_req;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [3:0]        w_mem_be;
    logic [31:0]       w_mem_wdata;
    logic [31:0]       w_mem_rdata;
    logic              w_mem_ack;

    modport master (
        output w_mem_req, w_mem_we, w_mem_addr, w_mem_be, w_mem_wdata,
        input  w_mem_rdata, w_mem_ack
    );
    modport slave (
        input  w_mem_req, w_mem_we, w_mem_addr, w_mem_be, w_mem_wdata,
        output w_mem_rdata, w_mem_ack
    );
endinterface

// File: rtl/dram_req_port_lane_steer.sv
// ----------------------------------------------------------------------------
// dram_lane_steer
// Combinational byte-lane steering.
//   off_i, size_i, uns_i : byte offset in word, access size, unsigned load
//   hi_half_i            : 0 = first word of the access, 1 = spill word
//   wdata_i              : right-justified store data
//   rdata_lo_i/hi_i      : captured read words (hi = following word)
//   be_o, wdata_o        : lane enables / shifted store data for the half
//   odata_o              : extracted and extended load result
// Store data is shifted across a 64-bit window so the same logic yields both
// halves of a split access.
// ----------------------------------------------------------------------------
module dram_lane_steer
    import dram_req_port_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic        hi_half_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_lo_i,
    input  logic [31:0] rdata_hi_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] odata_o
);
    logic [7:0]  mask;
    logic [63:0] wshift;
    logic [31:0] rshift;

    assign mask    = lane_mask(size_i, off_i);
    assign wshift  = {32'd0, wdata_i} << {off_i, 3'b000};
    assign rshift  = 32'({rdata_hi_i, rdata_lo_i} >> {off_i, 3'b000});

    assign be_o    = hi_half_i ? mask[7:4]     : mask[3:0];
    assign wdata_o = hi_half_i ? wshift[63:32] : wshift[31:0];
    assign odata_o = load_extend(rshift, size_i, uns_i);
endmodule

// File: rtl/dram_req_port.sv
// ----------------------------------------------------------------------------
// dram_req_port
// Turns 1-cycle CPU/MMU load/store strobes into word-wide bus transactions
// with byte enables, then returns sign/zero-extended load data.
// Ports:
//   CLK, RST_X : clock, synchronous active-high reset
//   cpu        : dram_cpu_if.slave  (addr, wdata, ctrl, we_t, le / odata, busy)
//   mem        : dram_mem_if.master (req, we, addr, be, wdata / rdata, ack)
//   w_err      : sticky error (timeout, le+we_t together, size 3, dropped lanes)
// Parameters: TIMEOUT (ack watchdog in cycles, 0 = off), ADDR_W.
// Build option DRAM_MISALIGN_EN: accesses crossing a word boundary are split
// into two transactions; otherwise spilled lanes are dropped and w_err set.
// ----------------------------------------------------------------------------
module dram_req_port
    import dram_req_port_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int ADDR_W  = 32
) (
    input  logic       CLK,
    input  logic       RST_X,
    dram_cpu_if.slave  cpu,
    dram_mem_if.master mem,
    output logic       w_err
);
    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, odata_q, rd_lo_q, rd_hi;
    logic [1:0]        size_q;
    logic              uns_q, we_q, split_q, to_q, err_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              start, bad_size, ovf, split_n, illegal;
    logic [1:0]        size_n;
    logic              req, busy, hi_phase, ack, timeout_hit;
    logic [ADDR_W-1:0] word_base;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata, lane_odata;

    // Request decode in IDLE; size 3 is handled as a word access.
    assign start    = (state_q == ST_IDLE) && (cpu.w_dram_le || cpu.w_dram_we_t);
    assign bad_size = (cpu.w_dram_ctrl[1:0] == 2'b11);
    assign size_n   = bad_size ? SZ_W : cpu.w_dram_ctrl[1:0];
    assign ovf      = ({2'b00, cpu.w_dram_addr[1:0]} + {1'b0, size_bytes(size_n)}) > 4'd4;

`ifdef DRAM_MISALIGN_EN
    logic [31:0] rd_hi_q;
    assign split_n = ovf;
    assign illegal = (cpu.w_dram_le && cpu.w_dram_we_t) || bad_size;
    assign rd_hi   = rd_hi_q;
`else
    assign split_n = 1'b0;
    assign illegal = (cpu.w_dram_le && cpu.w_dram_we_t) || bad_size || ovf;
    assign rd_hi   = 32'd0;
`endif

    // An ack on the same edge as the watchdog limit still completes normally.
    assign ack         = req && mem.w_mem_ack;
    assign timeout_hit = (TIMEOUT != 0) && req && !mem.w_mem_ack && (cnt_q == CNT_LAST);

    // FSM: state register
    always_ff @(posedge CLK) begin
        if (RST_X) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_REQ1;
            ST_REQ1: begin
                if (ack)              state_d = split_q ? ST_REQ2 : ST_DONE;
                else if (timeout_hit) state_d = ST_DONE;
            end
            ST_REQ2: if (ack || timeout_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req      = 1'b0;
        busy     = 1'b0;
        hi_phase = 1'b0;
        case (state_q)
            ST_REQ1: begin req = 1'b1; busy = 1'b1; end
            ST_REQ2: begin req = 1'b1; busy = 1'b1; hi_phase = 1'b1; end
            ST_DONE: busy = 1'b1;
            default: ;
        endcase
    end

    // Datapath: request capture, watchdog, read capture, result update.
    always_ff @(posedge CLK) begin
        if (RST_X) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            split_q <= 1'b0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
            err_q   <= 1'b0;
            odata_q <= '0;
            rd_lo_q <= '0;
`ifdef DRAM_MISALIGN_EN
            rd_hi_q <= '0;
`endif
        end else begin
            if (start) begin
                addr_q  <= cpu.w_dram_addr;
                wdata_q <= cpu.w_dram_wdata;
                size_q  <= size_n;
                uns_q   <= cpu.w_dram_ctrl[2];
                we_q    <= cpu.w_dram_we_t;
                split_q <= split_n;
                cnt_q   <= '0;
                to_q    <= 1'b0;
                if (illegal) err_q <= 1'b1;
            end
            if (ack) begin
                cnt_q <= '0;  // next phase (if any) starts a fresh watchdog
`ifdef DRAM_MISALIGN_EN
                if (hi_phase) rd_hi_q <= mem.w_mem_rdata;
                else          rd_lo_q <= mem.w_mem_rdata;
`else
                rd_lo_q <= mem.w_mem_rdata;
`endif
            end else if (timeout_hit) begin
                to_q  <= 1'b1;
                err_q <= 1'b1;
            end else if (req && (TIMEOUT != 0)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            // Stores leave the last load result untouched.
            if ((state_q == ST_DONE) && !we_q)
                odata_q <= to_q ? 32'hFFFF_FFFF : lane_odata;
        end
    end

    dram_lane_steer u_steer (
        .off_i      (addr_q[1:0]),
        .size_i     (size_q),
        .uns_i      (uns_q),
        .hi_half_i  (hi_phase),
        .wdata_i    (wdata_q),
        .rdata_lo_i (rd_lo_q),
        .rdata_hi_i (rd_hi),
        .be_o       (lane_be),
        .wdata_o    (lane_wdata),
        .odata_o    (lane_odata)
    );

    // Bus outputs are driven only while a request is open; wraps at 2^ADDR_W.
    assign word_base       = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem.w_mem_req   = req;
    assign mem.w_mem_we    = req && we_q;
    assign mem.w_mem_addr  = !req ? '0 : (hi_phase ? word_base + ADDR_W'(4) : word_base);
    assign mem.w_mem_be    = req ? lane_be : 4'd0;
    assign mem.w_mem_wdata = req ? lane_wdata : 32'd0;

    assign cpu.w_dram_busy  = busy;
    assign cpu.w_dram_odata = odata_q;
    assign w_err            = err_q;
endmodule

// File: tb/tb_dram_req_port.sv
// ----------------------------------------------------------------------------
// tb_dram_req_port
// Drives directed and random load/store accesses into dram_req_port, plays
// the memory side with chosen ack delays and read words, and compares bus
// transactions, busy, odata and err against a byte-by-byte reference model.
// ----------------------------------------------------------------------------
module tb_dram_req_port;
`ifdef DRAM_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    logic err;
    int   n_cmp = 0;
    int   n_err = 0;
    logic        exp_err;
    logic [31:0] exp_odata;

    dram_cpu_if #(.ADDR_W(32)) cpu ();
    dram_mem_if #(.ADDR_W(32)) mem ();

    dram_req_port #(.TIMEOUT(TO), .ADDR_W(32)) dut (
        .CLK   (clk),
        .RST_X (rst),
        .cpu   (cpu),
        .mem   (mem),
        .w_err (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete access. The model walks the accessed bytes one at a time
    // and places each in its lane of the first or the following word.
    task automatic run_access(input bit st, input bit ld, input logic [31:0] a,
                              input logic [31:0] wd, input logic [2:0] ctl,
                              input int d0, input int d1,
                              input logic [31:0] rd0, input logic [31:0] rd1,
                              input bit poke);
        int          sz, o, p, n_tx;
        bit          split;
        logic [31:0] t_addr [2];
        logic [3:0]  t_be   [2];
        logic [31:0] t_wd   [2];
        logic [31:0] rd     [2];
        int          dl     [2];
        logic [31:0] val;

        sz    = (ctl[1:0] == 2'd0) ? 1 : (ctl[1:0] == 2'd1) ? 2 : 4;
        o     = int'(a[1:0]);
        split = MIS_EN && (o + sz > 4);
        n_tx  = split ? 2 : 1;
        if ((st && ld) || (ctl[1:0] == 2'd3) || (!MIS_EN && (o + sz > 4))) exp_err = 1'b1;

        t_addr[0] = {a[31:2], 2'b00};
        t_addr[1] = t_addr[0] + 32'd4;
        t_be[0] = 4'd0;
        t_be[1] = 4'd0;
        t_wd[0] = wd << (8 * o);
        t_wd[1] = (o == 0) ? 32'd0 : (wd >> (8 * (4 - o)));
        rd[0] = rd0;  rd[1] = rd1;
        dl[0] = d0;   dl[1] = d1;
        val = 32'd0;
        for (int i = 0; i < sz; i++) begin
            p = o + i;
            if (p < 4) begin
                t_be[0][p] = 1'b1;
                val[8*i +: 8] = rd0[8*p +: 8];
            end else if (split) begin
                t_be[1][p-4] = 1'b1;
                val[8*i +: 8] = rd1[8*(p-4) +: 8];
            end
        end
        if (!ctl[2] && sz == 1)      val = {{24{val[7]}}, val[7:0]};
        else if (!ctl[2] && sz == 2) val = {{16{val[15]}}, val[15:0]};
        if (!st) exp_odata = val;

        cpu.w_dram_addr  = a;
        cpu.w_dram_wdata = wd;
        cpu.w_dram_ctrl  = ctl;
        cpu.w_dram_we_t  = st;
        cpu.w_dram_le    = ld;
        @(posedge clk); #1;
        cpu.w_dram_we_t  = 1'b0;
        cpu.w_dram_le    = 1'b0;
        cpu.w_dram_addr  = $urandom;
        cpu.w_dram_wdata = $urandom;
        cpu.w_dram_ctrl  = 3'($urandom);
        check_eq("busy_start", cpu.w_dram_busy, 1);

        for (int t = 0; t < n_tx; t++) begin
            check_eq("req", mem.w_mem_req, 1);
            check_eq("we", mem.w_mem_we, st);
            check_eq("addr", mem.w_mem_addr, t_addr[t]);
            check_eq("be", mem.w_mem_be, t_be[t]);
            if (st) check_eq("wdata", mem.w_mem_wdata, t_wd[t]);
            for (int c = 1; c < dl[t]; c++) begin
                if (poke) cpu.w_dram_le = 1'($urandom);  // must be ignored while busy
                @(posedge clk); #1;
                cpu.w_dram_le = 1'b0;
                check_eq("req_hold", mem.w_mem_req, 1);
            end
            mem.w_mem_ack   = 1'b1;
            mem.w_mem_rdata = rd[t];
            @(posedge clk); #1;
            mem.w_mem_ack   = 1'b0;
            mem.w_mem_rdata = $urandom;
        end
        check_eq("busy_done", cpu.w_dram_busy, 1);
        check_eq("req_drop", mem.w_mem_req, 0);
        @(posedge clk); #1;
        check_eq("busy_end", cpu.w_dram_busy, 0);
        check_eq("odata", cpu.w_dram_odata, exp_odata);
        check_eq("err", err, exp_err);
        $display("txn %s addr=%08h ctrl=%03b ntx=%0d odata=%08h err=%0b",
                 st ? "ST" : "LD", a, ctl, n_tx, cpu.w_dram_odata, err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int cyc;
        int r;
        rst = 1'b1;
        exp_err = 1'b0;
        exp_odata = 32'd0;
        cpu.w_dram_addr = '0; cpu.w_dram_wdata = '0; cpu.w_dram_ctrl = '0;
        cpu.w_dram_we_t = 1'b0; cpu.w_dram_le = 1'b0;
        mem.w_mem_ack = 1'b0; mem.w_mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", cpu.w_dram_busy, 0);
        check_eq("rst_req", mem.w_mem_req, 0);
        check_eq("rst_we", mem.w_mem_we, 0);
        check_eq("rst_be", mem.w_mem_be, 0);
        check_eq("rst_addr", mem.w_mem_addr, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_odata", cpu.w_dram_odata, 0);
        rst = 1'b0;

        // Ack while idle is ignored.
        mem.w_mem_ack = 1'b1;
        @(posedge clk); #1;
        mem.w_mem_ack = 1'b0;
        check_eq("idle_ack_busy", cpu.w_dram_busy, 0);
        check_eq("idle_ack_req", mem.w_mem_req, 0);

        // Directed cases.
        run_access(1, 0, 32'h8000_0003, 32'h0000_00A5, 3'b000, 3, 1, 32'h0, 32'h0, 0);
        run_access(0, 1, 32'h8000_0002, 32'h0, 3'b001, 2, 1, 32'h8123_4567, 32'h0, 0);
        run_access(0, 1, 32'h8000_0002, 32'h0, 3'b101, 1, 1, 32'h8123_4567, 32'h0, 0);
        run_access(0, 1, 32'h0000_0010, 32'h0, 3'b010, 1, 1, 32'h1357_9BDF, 32'h0, 0);
        run_access(1, 0, 32'h0000_0102, 32'hDDCC_BBAA, 3'b010, 2, 2, 32'h0, 32'h0, 0);
        run_access(0, 1, 32'h0000_0102, 32'h0, 3'b010, 2, 3, 32'hBBAA_1234, 32'h5678_DDCC, 0);
        run_access(1, 0, 32'hFFFF_FFFF, 32'h0000_BEEF, 3'b001, 1, 2, 32'h0, 32'h0, 0);
        run_access(0, 1, 32'h0000_0021, 32'h0, 3'b000, 1, 1, 32'h0000_F000, 32'h0, 0);
        run_access(1, 0, 32'h0000_0030, 32'h1122_3344, 3'b011, 1, 1, 32'h0, 32'h0, 0);
        run_access(1, 1, 32'h0000_0040, 32'h5566_7788, 3'b010, 2, 1, 32'h0, 32'h0, 0);

        // Random accesses, including strobes injected while busy.
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            run_access(r <= 4, (r == 0) || (r >= 5), $urandom, $urandom, 3'($urandom),
                       $urandom_range(1, 5), $urandom_range(1, 5), $urandom, $urandom, 1);
        end

        // Watchdog: load with no ack.
        cpu.w_dram_addr = 32'h40; cpu.w_dram_ctrl = 3'b010; cpu.w_dram_le = 1'b1;
        @(posedge clk); #1;
        cpu.w_dram_le = 1'b0;
        cyc = 0;
        for (int n = 0; n < 20 && mem.w_mem_req; n++) begin
            cyc++;
            @(posedge clk); #1;
        end
        check_eq("to_req_cycles", cyc, TO);
        check_eq("to_err", err, 1);
        check_eq("to_busy_done", cpu.w_dram_busy, 1);
        @(posedge clk); #1;
        check_eq("to_busy", cpu.w_dram_busy, 0);
        check_eq("to_odata", cpu.w_dram_odata, 32'hFFFF_FFFF);
        $display("txn LD addr=00000040 timeout odata=%08h err=%0b", cpu.w_dram_odata, err);

        // Reset in REQ1, then a stray ack.
        cpu.w_dram_addr = 32'h20; cpu.w_dram_ctrl = 3'b010; cpu.w_dram_le = 1'b1;
        @(posedge clk); #1;
        cpu.w_dram_le = 1'b0;
        check_eq("pre_rst_req", mem.w_mem_req, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("mid_rst_req", mem.w_mem_req, 0);
        check_eq("mid_rst_busy", cpu.w_dram_busy, 0);
        check_eq("mid_rst_err", err, 0);
        mem.w_mem_ack = 1'b1; mem.w_mem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        mem.w_mem_ack = 1'b0;
        check_eq("post_rst_busy", cpu.w_dram_busy, 0);
        check_eq("post_rst_req", mem.w_mem_req, 0);
        check_eq("post_rst_odata", cpu.w_dram_odata, 0);
        $display("txn RST mid-request busy=%0b err=%0b", cpu.w_dram_busy, err);
        exp_err = 1'b0;
        exp_odata = 32'd0;
        run_access(0, 1, 32'h0000_0024, 32'h0, 3'b000, 2, 1, 32'h0000_0080, 32'h0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
